// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the default PC and instruction widths, the fetch FSM encodings and the next-PC select codes.
// There is no logic here, so it adds no latency and needs no backpressure handling.
package pc_fetch_unit_pkg;

  localparam int PC_W_DEF    = 6;
  localparam int INSTR_W_DEF = 16;

  // Fetch FSM encoding. The state register can also hold 3, which is not
  // a valid state; the FSM sends that value back to BOOT.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // Reason the next-PC mux picked its output, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    SEL_HALT  = 2'd0,
    SEL_BRA   = 2'd1,
    SEL_STALL = 2'd2,
    SEL_SEQ   = 2'd3
  } nxt_sel_t;

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Next-PC priority select for the RUN state: halt, then branch, then stall, then PC+1.
// Purely combinational, so it adds no cycles of latency.
// There is no backpressure input; a stall is one of the select inputs.
// Ports: i_pc (current PC), i_bra_pc (branch target), i_halt_req, i_pcsrc, i_stall,
//        o_pc_nxt (selected next PC), o_sel (which rule fired).
module pc_next_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_bra_pc,
  input  logic            i_halt_req,
  input  logic            i_pcsrc,
  input  logic            i_stall,
  output logic [PC_W-1:0] o_pc_nxt,
  output nxt_sel_t        o_sel
);

  logic [PC_W-1:0] w_pc_inc;

  // The add wraps naturally at PC_W bits, so all-ones rolls over to zero.
  assign w_pc_inc = i_pc + PC_W'(1);

  always_comb begin
    o_pc_nxt = w_pc_inc;
    o_sel    = SEL_SEQ;
    if (i_halt_req) begin
      o_pc_nxt = i_pc;
      o_sel    = SEL_HALT;
    end else if (i_pcsrc) begin
      o_pc_nxt = i_bra_pc;
      o_sel    = SEL_BRA;
    end else if (i_stall) begin
      o_pc_nxt = i_pc;
      o_sel    = SEL_STALL;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: holds the PC, steps the BOOT/RUN/HALTED FSM and loads the IF/ID register.
// Latency: a redirect takes effect on imem_addr one cycle after it is seen; fetched data is registered into IF/ID.
// Backpressure: stall holds both the PC and IF/ID, but a taken branch overrides the stall.
// Ports: clk, rst_n (synchronous, active low), stall, pcsrc, pcsrc2, bra_pc, halt_req,
//        imem_data -> imem_addr, if_id_instr, if_id_pc1, if_id_valid, flush_id_ex, fetch_state.
// Optional build: FETCH_BRA_STATS_EN adds bra_count, a 16-bit saturating count of taken branches seen in RUN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               pcsrc,
  input  logic               pcsrc2,
  input  logic [PC_W-1:0]    bra_pc,
  input  logic               halt_req,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic               flush_id_ex,
`ifdef FETCH_BRA_STATS_EN
  output logic [15:0]        bra_count,
`endif
  output logic [1:0]         fetch_state
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc1;
  logic               r_valid;

  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [PC_W-1:0]    w_pc1_nxt;
  logic               w_valid_nxt;

  logic [PC_W-1:0]    w_mux_pc;
  nxt_sel_t           w_mux_sel;

  pc_next_mux #(
    .PC_W (PC_W)
  ) u_pc_next_mux (
    .i_pc       (r_pc),
    .i_bra_pc   (bra_pc),
    .i_halt_req (halt_req),
    .i_pcsrc    (pcsrc),
    .i_stall    (stall),
    .o_pc_nxt   (w_mux_pc),
    .o_sel      (w_mux_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc1_nxt   = r_pc1;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_BOOT: begin
        w_pc_nxt    = '0;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_pc_nxt = w_mux_pc;
        case (w_mux_sel)
          SEL_HALT: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_HALTED;
          end
          // The word fetched in this cycle is on the wrong path, so it is
          // dropped rather than loaded into IF/ID.
          SEL_BRA: w_valid_nxt = 1'b0;
          SEL_STALL: ;
          default: begin
            w_instr_nxt = imem_data;
            w_pc1_nxt   = w_mux_pc;
            w_valid_nxt = 1'b1;
          end
        endcase
      end
      ST_HALTED: ;
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= '0;
      r_instr <= '0;
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc1   <= w_pc1_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef FETCH_BRA_STATS_EN
  logic [15:0] r_bra_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bra_count <= '0;
    end else if ((r_state == ST_RUN) && pcsrc && (r_bra_count != 16'hFFFF)) begin
      r_bra_count <= r_bra_count + 16'd1;
    end
  end

  assign bra_count = r_bra_count;
`endif

  // BOOT always fetches from address 0. This also covers the case where BOOT
  // is entered from the unused encoding with a stale PC still in the register.
  assign imem_addr   = (r_state == ST_BOOT) ? '0 : r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc1   = r_pc1;
  assign if_id_valid = r_valid;
  assign fetch_state = r_state;

  // An EXE-stage branch squashes ID/EX only when it is also a real taken
  // branch. pcsrc2 on its own is ignored.
  assign flush_id_ex = rst_n && (r_state == ST_RUN) && pcsrc && pcsrc2;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        pcsrc;
  logic        pcsrc2;
  logic [5:0]  bra_pc;
  logic        halt_req;
  logic [15:0] imem_data;
  logic [5:0]  imem_addr;
  logic [15:0] if_id_instr;
  logic [5:0]  if_id_pc1;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic [1:0]  fetch_state;
`ifdef FETCH_BRA_STATS_EN
  logic [15:0] bra_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Each instruction word is tagged with its address: 0xA000 | addr.
  always_comb imem_data = {4'hA, 6'b0, imem_addr};

  pc_fetch_unit #(.PC_W(6), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .pcsrc2      (pcsrc2),
    .bra_pc      (bra_pc),
    .halt_req    (halt_req),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .flush_id_ex (flush_id_ex),
`ifdef FETCH_BRA_STATS_EN
    .bra_count   (bra_count),
`endif
    .fetch_state (fetch_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Takes a branch to the given target and returns with PC equal to that target.
  task automatic go_to(input logic [5:0] tgt);
    pcsrc  = 1'b1;
    bra_pc = tgt;
    step();
    pcsrc  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b1; pcsrc2 = 1'b1;
    bra_pc = 6'd9; halt_req = 1'b0;
    step();
    step();
    // Reset state. flush_id_ex must stay low while rst_n is low.
    chk("rst_flush", flush_id_ex, 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_state", fetch_state, 0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_pc1",   if_id_pc1, 0);
    chk("rst_instr", if_id_instr, 0);
    pcsrc = 1'b0; pcsrc2 = 1'b0; bra_pc = 6'd0;
    rst_n = 1'b1;

    // Free run after reset: imem_addr 0,0,1,2,3 and if_id_valid 0,0,1,1,1.
    chk("boot_addr", imem_addr, 0);
    chk("boot_valid", if_id_valid, 0);
    step();
    chk("run0_state", fetch_state, 1);
    chk("run0_addr", imem_addr, 0);
    chk("run0_valid", if_id_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("fr_addr",  imem_addr, i);
      chk("fr_pc1",   if_id_pc1, i);
      chk("fr_valid", if_id_valid, 1);
      chk("fr_instr", if_id_instr, 32'hA000 + i - 1);
    end

    // Branch taken at PC=10 to 40, with no EXE-stage flush.
    go_to(6'd10);
    chk("pc10", imem_addr, 10);
    pcsrc = 1'b1; bra_pc = 6'd40; pcsrc2 = 1'b0;
    #1;
    chk("b40_flush", flush_id_ex, 0);
    step();
    pcsrc = 1'b0;
    chk("b40_addr", imem_addr, 40);
    chk("b40_valid", if_id_valid, 0);
    step();
    chk("b40_seq_addr", imem_addr, 41);
    chk("b40_seq_instr", if_id_instr, 32'hA028);
    chk("b40_seq_pc1", if_id_pc1, 41);

    // EXE-stage branch at PC=20 while stalled: the branch wins and flush is asserted the same cycle.
    go_to(6'd20);
    pcsrc = 1'b1; pcsrc2 = 1'b1; bra_pc = 6'd5; stall = 1'b1;
    #1;
    chk("b5_flush", flush_id_ex, 1);
    step();
    pcsrc = 1'b0; pcsrc2 = 1'b0; stall = 1'b0;
    #1;
    chk("b5_addr", imem_addr, 5);
    chk("b5_valid", if_id_valid, 0);
    chk("b5_flush_off", flush_id_ex, 0);

    // PC wraps from 63 to 0, then a 3-cycle stall freezes PC and IF/ID.
    go_to(6'd63);
    chk("pc63", imem_addr, 63);
    step();
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_pc1", if_id_pc1, 0);
    chk("wrap_instr", if_id_instr, 32'hA03F);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_addr",  imem_addr, 1);
      chk("stl_pc1",   if_id_pc1, 1);
      chk("stl_instr", if_id_instr, 32'hA000);
      chk("stl_valid", if_id_valid, 1);
    end
    stall = 1'b0;
    // pcsrc2 without pcsrc is not a legal combination; only pcsrc is acted on.
    pcsrc2 = 1'b1;
    #1;
    chk("ill_flush", flush_id_ex, 0);
    step();
    pcsrc2 = 1'b0;
    chk("ill_addr", imem_addr, 2);
    chk("ill_valid", if_id_valid, 1);

    // Halt at PC=7: later branches are ignored and only reset leaves HALTED.
    go_to(6'd7);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("h_state", fetch_state, 2);
    chk("h_addr", imem_addr, 7);
    chk("h_valid", if_id_valid, 0);
    pcsrc = 1'b1; pcsrc2 = 1'b1; bra_pc = 6'd30;
    #1;
    chk("h_flush", flush_id_ex, 0);
    step();
    step();
    chk("h_br_addr", imem_addr, 7);
    chk("h_br_state", fetch_state, 2);
`ifdef FETCH_BRA_STATS_EN
    // Taken branches counted in RUN: 10, 40, 20, 5, 63 and 7.
    chk("cnt", bra_count, 6);
`endif
    rst_n = 1'b0;
    step();
    chk("hr_addr", imem_addr, 0);
    chk("hr_state", fetch_state, 0);
    chk("hr_valid", if_id_valid, 0);
    chk("hr_pc1", if_id_pc1, 0);
`ifdef FETCH_BRA_STATS_EN
    chk("cnt_rst", bra_count, 0);
`endif
    rst_n = 1'b1; pcsrc = 1'b0; pcsrc2 = 1'b0;
    step();
    chk("hr_run", fetch_state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
